// File: rtl/imm_ext_shift_pipe_pkg.sv
// Shared definitions for the immediate extend/shift pipeline: mode
// encodings, the datapath width and small mode-decoding helpers.
package imm_ext_shift_pipe_pkg;

    localparam int DATAPATH_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_LONG_SIGN  = 2'b00,
        MODE_SHORT_SIGN = 2'b01,
        MODE_LONG_ZERO  = 2'b10,
        MODE_SHORT_ZERO = 2'b11
    } imm_mode_e;

    // mode[0] selects the short field
    function automatic logic mode_is_short(input logic [1:0] mode);
        return mode[0];
    endfunction

    // mode[1] selects zero extension
    function automatic logic mode_is_zero(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/imm_ext_shift_pipe_if.sv
// Operand/result handshake bundle for the immediate extend/shift pipeline.
// The slave modport is the pipeline's view, master is the surrounding logic.
interface imm_ext_shift_pipe_if
    import imm_ext_shift_pipe_pkg::*;
#(
    parameter int IN_WIDTH    = 12,
    parameter int OUT_WIDTH   = DATAPATH_WIDTH,
    parameter int SHAMT_WIDTH = 3
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    data_in;
    logic [1:0]             mode;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   data_out;
    logic                   overflow;

    modport slave (
        input  in_valid, data_in, mode, shamt, out_ready,
        output in_ready, out_valid, data_out, overflow
    );

    modport master (
        output in_valid, data_in, mode, shamt, out_ready,
        input  in_ready, out_valid, data_out, overflow
    );

endinterface

// File: rtl/imm_ext_shift_stage.sv
// Generic valid/ready pipeline register. The stage loads whenever it is
// empty or its content is being consumed downstream; ready upstream is
// therefore combinational from down_ready (no skid buffer).
module imm_ext_shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             advance_s;

    // Stage may take new content when empty or when being drained
    always_comb begin
        advance_s = !valid_r || down_ready;
    end

    // Occupancy and payload register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (advance_s) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign up_ready   = advance_s;
    assign down_valid = valid_r;
    assign down_data  = data_r;

endmodule

// File: rtl/imm_ext_shift_pipe.sv
// Two-stage immediate extender and left shifter. Stage 1 registers the
// extended field, its sign and the shift amount; stage 2 registers the
// shifted value and an overflow flag that is set when the truncated result
// no longer equals the exact (infinitely wide) shifted value.
module imm_ext_shift_pipe
    import imm_ext_shift_pipe_pkg::*;
#(
    parameter int IN_WIDTH    = 12,
    parameter int SHORT_WIDTH = 8,
    parameter int OUT_WIDTH   = DATAPATH_WIDTH,
    parameter int SHAMT_WIDTH = 3
) (
    input logic                clk,
    input logic                rst_n,
    imm_ext_shift_pipe_if.slave bus
);

    localparam int PAD_W  = (2 ** SHAMT_WIDTH) - 1;
    localparam int FULL_W = OUT_WIDTH + PAD_W;
    localparam int S1_W   = 2 + OUT_WIDTH + SHAMT_WIDTH;
    localparam int S2_W   = 1 + OUT_WIDTH;

    logic                   field_msb_s;
    logic                   sign_s;
    logic [OUT_WIDTH-1:0]   ext_s;
    logic [S1_W-1:0]        s1_in_s;
    logic [S1_W-1:0]        s1_out_s;
    logic                   s1_valid_s;
    logic                   s1_ready_s;
    logic                   in_ready_s;
    logic                   s1_zero_s;
    logic                   s1_sign_s;
    logic [OUT_WIDTH-1:0]   s1_ext_s;
    logic [SHAMT_WIDTH-1:0] s1_shamt_s;
    logic [FULL_W-1:0]      full_s;
    logic [PAD_W:0]         hi_s;
    logic                   ovf_s;
    logic [S2_W-1:0]        s2_in_s;
    logic [S2_W-1:0]        s2_out_s;
    logic                   s2_valid_s;

    // Select the immediate field and extend it to the datapath width
    always_comb begin
        if (mode_is_short(bus.mode)) begin
            field_msb_s = bus.data_in[SHORT_WIDTH-1];
        end else begin
            field_msb_s = bus.data_in[IN_WIDTH-1];
        end
        if (mode_is_zero(bus.mode)) begin
            sign_s = 1'b0;
        end else begin
            sign_s = field_msb_s;
        end
        ext_s = {OUT_WIDTH{sign_s}};
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (!mode_is_short(bus.mode) || (i < SHORT_WIDTH)) begin
                ext_s[i] = bus.data_in[i];
            end else begin
                ext_s[i] = sign_s;
            end
        end
        s1_in_s = {mode_is_zero(bus.mode), sign_s, ext_s, bus.shamt};
    end

    imm_ext_shift_stage #(.WIDTH(S1_W)) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (bus.in_valid),
        .up_ready   (in_ready_s),
        .up_data    (s1_in_s),
        .down_valid (s1_valid_s),
        .down_ready (s1_ready_s),
        .down_data  (s1_out_s)
    );

    assign {s1_zero_s, s1_sign_s, s1_ext_s, s1_shamt_s} = s1_out_s;

    // Shift the sign-extended value and detect loss of the exact result;
    // sign modes also require the new result MSB to match the sign
    always_comb begin
        full_s = {{PAD_W{s1_sign_s}}, s1_ext_s} << s1_shamt_s;
        hi_s   = full_s[FULL_W-1:OUT_WIDTH-1];
        if (s1_zero_s) begin
            ovf_s = |hi_s[PAD_W:1];
        end else begin
            ovf_s = |(hi_s ^ {(PAD_W + 1){s1_sign_s}});
        end
        s2_in_s = {ovf_s, full_s[OUT_WIDTH-1:0]};
    end

    imm_ext_shift_stage #(.WIDTH(S2_W)) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (s1_valid_s),
        .up_ready   (s1_ready_s),
        .up_data    (s2_in_s),
        .down_valid (s2_valid_s),
        .down_ready (bus.out_ready),
        .down_data  (s2_out_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_s;
    assign bus.overflow  = s2_out_s[S2_W-1];
    assign bus.data_out  = s2_out_s[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_imm_ext_shift_pipe.sv
// Self-checking bench for imm_ext_shift_pipe: fixed vector table, hand
// sequences for reset/backpressure, random streaming against an arithmetic
// reference model, all results routed through a scoreboard queue.
module tb_imm_ext_shift_pipe;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] din;
        logic [2:0]  shamt;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          stamp;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   n_out;
    logic lat_chk;
    logic ovr_en;
    logic [16:0] ovr_val;
    sb_entry_t sb[$];
    vec_t vecs[11];

    imm_ext_shift_pipe_if #(.IN_WIDTH(12), .OUT_WIDTH(16), .SHAMT_WIDTH(3)) bus ();

    imm_ext_shift_pipe #(
        .IN_WIDTH(12), .SHORT_WIDTH(8), .OUT_WIDTH(16), .SHAMT_WIDTH(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact arithmetic reference: value times 2^shamt, then range test
    function automatic logic [16:0] model(input logic [1:0] m, input logic [11:0] d,
                                          input logic [2:0] s);
        longint v;
        longint e;
        logic   o;
        if (m[0]) v = longint'(d[7:0]);
        else      v = longint'(d);
        if (!m[1]) begin
            if (m[0] && d[7])       v = v - 256;
            else if (!m[0] && d[11]) v = v - 4096;
        end
        e = v * (longint'(1) << s);
        if (m[1]) o = (e > 65535);
        else      o = (e > 32767) || (e < -32768);
        return {o, e[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Evaluate transfers just after the inputs settle, then advance one clock
    task automatic tick();
        sb_entry_t e;
        logic [16:0] m;
        #1;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data_out=%h, expected no output (cycle %0d)",
                             bus.data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("data_out", 32'(bus.data_out), 32'(e.data));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    if (lat_chk) check("latency", 32'(cyc - e.stamp), 32'd2);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m = ovr_en ? ovr_val : model(bus.mode, bus.data_in, bus.shamt);
                e.data  = m[15:0];
                e.ovf   = m[16];
                e.stamp = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic drive(input logic [1:0] m, input logic [11:0] d, input logic [2:0] s);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.data_in  = d;
        bus.shamt    = s;
    endtask

    initial begin
        int n0;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        n_out   = 0;
        lat_chk = 1'b0;
        ovr_en  = 1'b0;
        ovr_val = 17'h0_0000;

        vecs[0]  = '{2'b00, 12'h881, 3'd1, 16'hF102, 1'b0};
        vecs[1]  = '{2'b01, 12'h881, 3'd1, 16'hFF02, 1'b0};
        vecs[2]  = '{2'b10, 12'h881, 3'd1, 16'h1102, 1'b0};
        vecs[3]  = '{2'b11, 12'h881, 3'd1, 16'h0102, 1'b0};
        vecs[4]  = '{2'b10, 12'h800, 3'd5, 16'h0000, 1'b1};
        vecs[5]  = '{2'b00, 12'h400, 3'd5, 16'h8000, 1'b1};
        vecs[6]  = '{2'b00, 12'hFFF, 3'd7, 16'hFF80, 1'b0};
        vecs[7]  = '{2'b11, 12'h0FF, 3'd7, 16'h7F80, 1'b0};
        vecs[8]  = '{2'b01, 12'h080, 3'd0, 16'hFF80, 1'b0};
        vecs[9]  = '{2'b00, 12'h7FF, 3'd4, 16'h7FF0, 1'b0};
        vecs[10] = '{2'b00, 12'h7FF, 3'd5, 16'hFFE0, 1'b1};

        // Reset with an operand offered: nothing may come out of it
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 12'h123, 3'd2);
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'h0000);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // Fixed vectors, back-to-back
        ovr_en = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].din, vecs[i].shamt);
            ovr_val = {vecs[i].exp_ovf, vecs[i].exp_data};
            tick();
        end
        ovr_en = 1'b0;
        drain();

        // Backpressure: two accepts then stall, output held stable
        bus.out_ready = 1'b0;
        drive(2'b10, 12'h001, 3'd0);
        tick();
        drive(2'b10, 12'h002, 3'd0);
        tick();
        drive(2'b10, 12'h003, 3'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.data_out), 32'h0001);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("bp_release_valid", 32'(bus.out_valid), 32'd1);
            check("bp_release_data", 32'(bus.data_out), 32'(k));
            tick();
            bus.in_valid = 1'b0;
        end
        drain();

        // Random streaming at full rate with latency tracking
        lat_chk = 1'b1;
        n0      = n_out;
        for (int k = 0; k < 16; k++) begin
            drive(2'($urandom_range(3, 0)), 12'($urandom), 3'($urandom_range(7, 0)));
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        drain();
        check("stream_count", 32'(n_out - n0), 32'd16);
        lat_chk = 1'b0;

        // Reset with two operands in flight
        bus.out_ready = 1'b1;
        drive(2'b00, 12'h111, 3'd1);
        tick();
        drive(2'b00, 12'h222, 3'd1);
        tick();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        sb.delete();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        n0    = n_out;
        drive(2'b11, 12'h0A5, 3'd2);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("midrst_gap", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        check("midrst_new_valid", 32'(bus.out_valid), 32'd1);
        check("midrst_new_data", 32'(bus.data_out), 32'h0294);
        drain();
        check("midrst_count", 32'(n_out - n0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
